// File: rtl/imem_arbiter_pkg.sv
// Shared constants, response-register layout and PC legality check for the
// instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int ID_W        = 3;   // wide enough for up to 8 cores

  // addi x0, x0, 0
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  // Response pipeline register: everything needed to answer a grant one
  // cycle later.
  typedef struct packed {
    logic                   vld;
    logic [ID_W-1:0]        id;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   err;
  } rsp_reg_t;

  // A fetch PC is unusable when it is not word aligned or points past the
  // end of the instruction memory.
  function automatic logic pc_is_bad(input logic [XLEN-1:0] pc,
                                     input int unsigned     words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[XLEN-1:2]} >= XLEN'(words));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the first requester found scanning upward
// (circularly) from ptr wins. Purely combinational so it can be reused by
// any arbiter that owns its own pointer register.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;

  // Circular priority scan starting at ptr; at most one grant bit set.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + off) % N))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational instruction memory between NUM_CORES fetch
// ports. One grant per cycle, round-robin; the response for a grant in
// cycle t is presented in cycle t+1 from a single pipeline register.
//
// Handshake: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is one-hot and never asserted
// without req_valid. rsp_valid is a one-cycle one-hot strobe with no
// back-pressure; rsp_instr/rsp_err are zero whenever rsp_valid is zero.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int IMEM_WORDS = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES*XLEN-1:0]   req_pc,
  output logic [NUM_CORES-1:0]        req_ready,
  input  logic [NUM_CORES-1:0]        flush,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [INSTR_WIDTH-1:0]      rsp_instr,
  output logic                        rsp_err,
  output logic [XLEN-1:0]             mem_pc,
  input  logic [INSTR_WIDTH-1:0]      mem_instr
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] grant;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic                 gnt_bad;
  logic [NUM_CORES-1:0] rsp_hot;
  rsp_reg_t             rsp_q;

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = rst ? '0 : grant;
  assign gnt_any   = |req_ready;
  assign gnt_bad   = pc_is_bad(mem_pc, IMEM_WORDS);

  // Encode the one-hot grant and steer the winner's PC to the memory.
  always_comb begin
    gnt_id = '0;
    mem_pc = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (req_ready[i]) begin
        gnt_id = ID_W'(i);
        mem_pc = req_pc[i*XLEN +: XLEN];
      end
    end
  end

  // Advance the priority pointer past the winner and capture its response;
  // a flush in the grant cycle kills the response before it is stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      rsp_q  <= '0;
    end else if (gnt_any) begin
      rr_ptr      <= (int'(gnt_id) == NUM_CORES - 1) ? '0 : PTR_W'(gnt_id + 1'b1);
      rsp_q.vld   <= ~|(flush & req_ready);
      rsp_q.id    <= gnt_id;
      rsp_q.err   <= gnt_bad;
      rsp_q.instr <= gnt_bad ? NOP_INSTR : mem_instr;
    end else begin
      rsp_q.vld <= 1'b0;
    end
  end

  // Decode the stored core id; a flush in the response cycle also kills it.
  always_comb begin
    rsp_hot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      rsp_hot[i] = rsp_q.vld && (rsp_q.id == ID_W'(i));
    end
  end

  assign rsp_valid = rst ? '0 : (rsp_hot & ~flush);
  assign rsp_instr = (|rsp_valid) ? rsp_q.instr : '0;
  assign rsp_err   = (|rsp_valid) ? rsp_q.err   : 1'b0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a 2-core and a 4-core instance share reset and
// are both checked every cycle against a behavioural model. Directed
// sequences on the 2-core instance pin literal values; a random phase
// drives both instances.
module tb_imem_arbiter;

  logic         clk;
  logic         rst;

  logic [1:0]   v2, fl2, rdy2, rv2;
  logic [63:0]  pc2;
  logic [31:0]  ri2, mpc2, mi2;
  logic         re2;

  logic [3:0]   v4, fl4, rdy4, rv4;
  logic [127:0] pc4;
  logic [31:0]  ri4, mpc4, mi4;
  logic         re4;

  int total = 0;
  int bad   = 0;

  // Behavioural model state, index 0 = 2-core, 1 = 4-core.
  int          m_ptr  [2];
  bit          m_pv   [2];
  int          m_pcore[2];
  logic [31:0] m_ppc  [2];
  int          m_wait [2][8];

  // Memory contents: word i holds C0DE in the upper half and i below.
  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return {16'hC0DE, idx[15:0]};
  endfunction

  function automatic logic pc_bad(input logic [31:0] pc);
    return ((pc % 4) != 0) || ((pc / 4) >= 1024);
  endfunction

  assign mi2 = mem_word(mpc2 >> 2);
  assign mi4 = mem_word(mpc4 >> 2);

  imem_arbiter #(.NUM_CORES(2), .IMEM_WORDS(1024)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_pc(pc2), .req_ready(rdy2),
    .flush(fl2), .rsp_valid(rv2), .rsp_instr(ri2), .rsp_err(re2),
    .mem_pc(mpc2), .mem_instr(mi2)
  );

  imem_arbiter #(.NUM_CORES(4), .IMEM_WORDS(1024)) dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_pc(pc4), .req_ready(rdy4),
    .flush(fl4), .rsp_valid(rv4), .rsp_instr(ri4), .rsp_err(re4),
    .mem_pc(mpc4), .mem_instr(mi4)
  );

  // Clock / reset-free clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d act=%h exp=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Model of one instance for one cycle: compare outputs, then advance.
  task automatic model_check(input int k, input int n, input logic rs,
                             input logic [7:0] valid, input logic [7:0] flush,
                             input logic [7:0] ready, input logic [7:0] rspv,
                             input logic [255:0] pcs, input logic [31:0] instr,
                             input logic err, input logic [31:0] mpc);
    logic [7:0]  e_ready, e_rspv;
    logic [31:0] e_instr, e_mpc;
    logic        e_err;
    int          g, idx;
    e_ready = '0; e_rspv = '0; e_instr = '0; e_mpc = '0; e_err = 1'b0; g = -1;
    chk("onehot_ready", k, {31'b0, $countones(ready) <= 1}, 32'd1);
    chk("onehot_rspv",  k, {31'b0, $countones(rspv)  <= 1}, 32'd1);
    if (rs) begin
      chk("m_rst_ready", k, {24'b0, ready}, 32'd0);
      chk("m_rst_rspv",  k, {24'b0, rspv},  32'd0);
      chk("m_rst_instr", k, instr, 32'd0);
      chk("m_rst_err",   k, {31'b0, err}, 32'd0);
      m_ptr[k] = 0;
      m_pv[k]  = 1'b0;
      for (int i = 0; i < 8; i++) m_wait[k][i] = 0;
      return;
    end
    if (m_pv[k] && !flush[m_pcore[k]]) begin
      e_rspv[m_pcore[k]] = 1'b1;
      e_err   = pc_bad(m_ppc[k]);
      e_instr = e_err ? 32'h0000_0013 : mem_word(m_ppc[k] >> 2);
    end
    for (int off = 0; off < n; off++) begin
      idx = (m_ptr[k] + off) % n;
      if (g < 0 && valid[idx]) g = idx;
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_mpc      = pcs[g*32 +: 32];
    end
    chk("ready",  k, {24'b0, ready}, {24'b0, e_ready});
    chk("mem_pc", k, mpc, e_mpc);
    chk("rspv",   k, {24'b0, rspv}, {24'b0, e_rspv});
    chk("instr",  k, instr, e_instr);
    chk("err",    k, {31'b0, err}, {31'b0, e_err});
    for (int i = 0; i < n; i++) begin
      if (i == g) begin
        chk("fair_wait", k, {31'b0, m_wait[k][i] <= n - 1}, 32'd1);
        m_wait[k][i] = 0;
      end else if (valid[i]) begin
        m_wait[k][i]++;
      end else begin
        m_wait[k][i] = 0;
      end
    end
    if (g >= 0) begin
      m_ptr[k]   = (g + 1) % n;
      m_pv[k]    = !flush[g];
      m_pcore[k] = g;
      m_ppc[k]   = pcs[g*32 +: 32];
    end else begin
      m_pv[k] = 1'b0;
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    model_check(0, 2, rst, {6'b0, v2}, {6'b0, fl2}, {6'b0, rdy2}, {6'b0, rv2},
                {192'b0, pc2}, ri2, re2, mpc2);
    model_check(1, 4, rst, {4'b0, v4}, {4'b0, fl4}, {4'b0, rdy4}, {4'b0, rv4},
                {128'b0, pc4}, ri4, re4, mpc4);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned mode;
    mode = $urandom_range(0, 9);
    if (mode < 7)       return {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
    else if (mode == 7) return {20'b0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
    else if (mode == 8) return 32'($urandom_range(1024, 65535)) << 2;
    else                return ($urandom_range(0, 1) != 0) ? 32'h0000_0FFC : 32'h0000_1000;
  endfunction

  // Driver: directed sequences, then random traffic, then the report.
  initial begin
    rst = 1'b1; v2 = '0; fl2 = '0; pc2 = '0; v4 = '0; fl4 = '0; pc4 = '0;
    @(negedge clk);
    chk("rst_ready", 0, {30'b0, rdy2}, 32'd0);
    chk("rst_rspv",  0, {30'b0, rv2},  32'd0);
    chk("rst_instr", 0, ri2, 32'd0);
    chk("rst_err",   0, {31'b0, re2}, 32'd0);
    step(); step(); step();

    // Both cores requesting: grants alternate 0,1,0,1...
    rst = 1'b0; v2 = 2'b11; pc2 = {32'h0000_0100, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_ready", 0, {30'b0, rdy2}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_rspv",  0, {30'b0, rv2}, (i == 0) ? 32'd0 : ((i % 2 == 1) ? 32'd1 : 32'd2));
      if (i > 0)
        chk("alt_instr", 0, ri2, (i % 2 == 1) ? 32'hC0DE_0000 : 32'hC0DE_0040);
      step();
    end

    // Core 1 alone at pc 0x4.
    v2 = 2'b10; pc2 = {32'h0000_0004, 32'h0000_0000};
    @(negedge clk);
    chk("c1_ready", 0, {30'b0, rdy2}, 32'd2);
    step();
    v2 = 2'b00;
    @(negedge clk);
    chk("c1_rspv",  0, {30'b0, rv2}, 32'd2);
    chk("c1_instr", 0, ri2, 32'hC0DE_0001);
    chk("c1_err",   0, {31'b0, re2}, 32'd0);
    step();

    // Pointer back at 0, then out-of-range and misaligned PCs on core 0.
    v2 = 2'b11; pc2 = {32'h0000_0004, 32'h0000_1000};
    @(negedge clk);
    chk("ptr0_ready", 0, {30'b0, rdy2}, 32'd1);
    step();
    v2 = 2'b01; pc2 = {32'h0000_0004, 32'h0000_0002};
    @(negedge clk);
    chk("oor_rspv",  0, {30'b0, rv2}, 32'd1);
    chk("oor_instr", 0, ri2, 32'h0000_0013);
    chk("oor_err",   0, {31'b0, re2}, 32'd1);
    step();
    v2 = 2'b00;
    @(negedge clk);
    chk("mis_instr", 0, ri2, 32'h0000_0013);
    chk("mis_err",   0, {31'b0, re2}, 32'd1);
    step();

    // Flush of core 0 in its response cycle, core 1 granted meanwhile.
    v2 = 2'b01; pc2 = {32'h0000_000C, 32'h0000_0008};
    @(negedge clk);
    chk("fl_ready0", 0, {30'b0, rdy2}, 32'd1);
    step();
    v2 = 2'b10; fl2 = 2'b01;
    @(negedge clk);
    chk("fl_rspv0",  0, {30'b0, rv2}, 32'd0);
    chk("fl_ready1", 0, {30'b0, rdy2}, 32'd2);
    step();
    v2 = 2'b00; fl2 = 2'b00;
    @(negedge clk);
    chk("fl_rspv1",  0, {30'b0, rv2}, 32'd2);
    chk("fl_instr1", 0, ri2, 32'hC0DE_0003);
    step();
    // Flush in the grant cycle itself.
    v2 = 2'b01; fl2 = 2'b01;
    step();
    v2 = 2'b00; fl2 = 2'b00;
    @(negedge clk);
    chk("flg_rspv", 0, {30'b0, rv2}, 32'd0);
    chk("flg_instr", 0, ri2, 32'd0);
    step();

    // Reset right after a grant drops the response.
    v2 = 2'b11; pc2 = {32'h0000_0010, 32'h0000_0014};
    @(negedge clk);
    chk("pre_rst_ready", 0, {30'b0, rdy2}, 32'd2);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_rspv",  0, {30'b0, rv2}, 32'd0);
    chk("in_rst_ready", 0, {30'b0, rdy2}, 32'd0);
    step();
    rst = 1'b0; v2 = 2'b00;
    @(negedge clk);
    chk("post_rst_rspv", 0, {30'b0, rv2}, 32'd0);
    step();
    v2 = 2'b11;
    @(negedge clk);
    chk("post_rst_grant", 0, {30'b0, rdy2}, 32'd1);
    step();
    v2 = 2'b00;
    @(negedge clk);
    chk("post_rst_instr", 0, ri2, 32'hC0DE_0005);
    step();

    // Random traffic on both instances.
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) begin
        v2[i]  = ($urandom_range(0, 9) < 7);
        fl2[i] = ($urandom_range(0, 9) == 0);
        pc2[i*32 +: 32] = rand_pc();
      end
      for (int i = 0; i < 4; i++) begin
        v4[i]  = ($urandom_range(0, 9) < 7);
        fl4[i] = ($urandom_range(0, 9) == 0);
        pc4[i*32 +: 32] = rand_pc();
      end
      step();
    end
    rst = 1'b0; v2 = '0; fl2 = '0; v4 = '0; fl4 = '0;
    step(); step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
